// File: rtl/usb_pkg.sv
// Shared USB transmit definitions: PID bytes, handshake codes, scheduler
// states and helpers that build the 16-bit PID word offered to the datapath.
package usb_pkg;

    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;

    typedef enum logic [1:0] {
        HS_ACK   = 2'b00,
        HS_NAK   = 2'b01,
        HS_STALL = 2'b10,
        HS_RSVD  = 2'b11
    } hs_code_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HS_START,
        S_DATA_START,
        S_DATA_BODY,
        S_WAIT_EOP,
        S_GAP
    } tx_state_e;

    // Reserved code is sent as STALL.
    function automatic logic [15:0] hs_word(hs_code_e c);
        logic [7:0] pid;
        case (c)
            HS_ACK:  pid = PID_ACK;
            HS_NAK:  pid = PID_NAK;
            default: pid = PID_STALL;
        endcase
        return {8'h00, pid};
    endfunction

    function automatic logic [15:0] data_word(logic tgl);
        return {8'h00, (tgl ? PID_DATA1 : PID_DATA0)};
    endfunction

endpackage

// File: rtl/usb_ipg_timer.sv
// Loadable down-counter with zero flag (inter-packet gap / rx turnaround).
// Ports: clk_i, n_rst_i, clr_i, load_i, load_val_i, zero_o.
module usb_ipg_timer #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         n_rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/usb_tx_scheduler.sv
// USB tx scheduler: arbitrates handshake vs data packets, sequences the
// tx_data word stream, tracks the data toggle and enforces the IPG.
// Ports: hs_* / data_* requester sides, fifo_* source, transmit_* and
// tx_data/read_enable/eop_done toward the tx datapath, busy status.
module usb_tx_scheduler
    import usb_pkg::*;
#(
    parameter int IPG_CYCLES = 16,
    parameter int LEN_W      = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             usb_reset,
    input  logic             hs_req,
    input  logic [1:0]       hs_code,
    output logic             hs_gnt,
    input  logic             data_req,
    input  logic [LEN_W-1:0] data_len,
    output logic             data_done,
    input  logic             ack_rcvd,
    input  logic             toggle_clr,
    input  logic [LEN_W-1:0] fifo_level,
    input  logic [15:0]      fifo_rdata,
    output logic             fifo_rd,
    output logic             transmit_start,
    output logic             transmit_response,
    output logic             transmit_empty,
    output logic [15:0]      tx_data,
    input  logic             read_enable,
    input  logic             eop_done,
    output logic             busy
);

    localparam int CNT_W = $clog2(IPG_CYCLES + 1);

    tx_state_e        state_q;
    logic [15:0]      tx_data_q;
    logic             empty_q;
    logic             start_q;
    logic             resp_q;
    logic             gnt_q;
    logic             is_data_q;
    logic [LEN_W-1:0] words_q;
    logic             toggle_q;
    logic             toggle_d;
    logic             data_ok;
    logic             gap_load;
    logic             gap_zero;

    assign data_ok  = data_req && (fifo_level >= data_len);
    assign gap_load = (state_q == S_WAIT_EOP) && eop_done && !usb_reset;

    // Clear dominates a simultaneous ACK.
    always_comb begin
        toggle_d = toggle_q;
        if (usb_reset || toggle_clr) begin
            toggle_d = 1'b0;
        end else if (ack_rcvd) begin
            toggle_d = ~toggle_q;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    usb_ipg_timer #(
        .W(CNT_W)
    ) u_gap (
        .clk_i      (clk),
        .n_rst_i    (n_rst),
        .clr_i      (usb_reset),
        .load_i     (gap_load),
        .load_val_i (CNT_W'(IPG_CYCLES - 1)),
        .zero_o     (gap_zero)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            tx_data_q <= 16'h0000;
            empty_q   <= 1'b1;
            start_q   <= 1'b0;
            resp_q    <= 1'b0;
            gnt_q     <= 1'b0;
            is_data_q <= 1'b0;
            words_q   <= '0;
        end else begin
            start_q <= 1'b0;
            resp_q  <= 1'b0;
            gnt_q   <= 1'b0;
            if (usb_reset) begin
                state_q   <= S_IDLE;
                empty_q   <= 1'b1;
                is_data_q <= 1'b0;
                words_q   <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (hs_req) begin
                            state_q   <= S_HS_START;
                            tx_data_q <= hs_word(hs_code_e'(hs_code));
                            empty_q   <= 1'b1;
                            is_data_q <= 1'b0;
                        end else if (data_ok) begin
                            state_q   <= S_DATA_START;
                            tx_data_q <= data_word(toggle_q);
                            words_q   <= data_len;
                            empty_q   <= 1'b0;
                            is_data_q <= 1'b1;
                        end
                    end
                    S_HS_START: begin
                        resp_q  <= 1'b1;
                        gnt_q   <= 1'b1;
                        state_q <= S_WAIT_EOP;
                    end
                    S_DATA_START: begin
                        start_q <= 1'b1;
                        state_q <= S_DATA_BODY;
                    end
                    S_DATA_BODY: begin
                        // Each read_enable consumes the word on tx_data.
                        if (read_enable) begin
                            if (words_q != '0) begin
                                tx_data_q <= fifo_rdata;
                                words_q   <= words_q - 1'b1;
                            end else begin
                                empty_q <= 1'b1;
                                state_q <= S_WAIT_EOP;
                            end
                        end
                    end
                    S_WAIT_EOP: begin
                        if (eop_done) begin
                            state_q <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (gap_zero) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign fifo_rd = (state_q == S_DATA_BODY) && read_enable &&
                     (words_q != '0) && !usb_reset;
    assign data_done = (state_q == S_WAIT_EOP) && is_data_q &&
                       eop_done && !usb_reset;

    assign hs_gnt            = gnt_q;
    assign transmit_start    = start_q;
    assign transmit_response = resp_q;
    assign transmit_empty    = empty_q;
    assign tx_data           = tx_data_q;
    assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed self-checking bench for usb_tx_scheduler.
// Drives/samples 1 time unit after each rising edge.
module tb_usb_tx_scheduler;

    localparam int IPG   = 16;
    localparam int LEN_W = 7;

    logic             clk;
    logic             n_rst;
    logic             usb_reset;
    logic             hs_req;
    logic [1:0]       hs_code;
    logic             hs_gnt;
    logic             data_req;
    logic [LEN_W-1:0] data_len;
    logic             data_done;
    logic             ack_rcvd;
    logic             toggle_clr;
    logic [LEN_W-1:0] fifo_level;
    logic [15:0]      fifo_rdata;
    logic             fifo_rd;
    logic             transmit_start;
    logic             transmit_response;
    logic             transmit_empty;
    logic [15:0]      tx_data;
    logic             read_enable;
    logic             eop_done;
    logic             busy;

    logic [15:0] mem [0:15];
    logic        rp_clr;
    logic [3:0]  rp;
    int          n_chk;
    int          n_pass;

    usb_tx_scheduler #(
        .IPG_CYCLES (IPG),
        .LEN_W      (LEN_W)
    ) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .usb_reset         (usb_reset),
        .hs_req            (hs_req),
        .hs_code           (hs_code),
        .hs_gnt            (hs_gnt),
        .data_req          (data_req),
        .data_len          (data_len),
        .data_done         (data_done),
        .ack_rcvd          (ack_rcvd),
        .toggle_clr        (toggle_clr),
        .fifo_level        (fifo_level),
        .fifo_rdata        (fifo_rdata),
        .fifo_rd           (fifo_rd),
        .transmit_start    (transmit_start),
        .transmit_response (transmit_response),
        .transmit_empty    (transmit_empty),
        .tx_data           (tx_data),
        .read_enable       (read_enable),
        .eop_done          (eop_done),
        .busy              (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Show-ahead FIFO model; pointer advances on each pop.
    always @(posedge clk or posedge rp_clr) begin
        if (rp_clr) rp <= 4'd0;
        else if (fifo_rd) rp <= rp + 4'd1;
    end
    assign fifo_rdata = mem[rp];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_fifo();
        rp_clr = 1'b1;
        #1;
        rp_clr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        check({tag, ".ipg"}, n, IPG);
    endtask

    // From first DATA_BODY cycle: read PID + len words, then EOP.
    task automatic body(input string tag, input int len);
        for (int k = 0; k <= len; k++) begin
            check({tag, ".emp0"}, transmit_empty, 1'b0);
            read_enable = 1'b1;
            #1;
            check({tag, ".rd"}, fifo_rd, (k < len));
            step();
            read_enable = 1'b0;
            if (k < len) check({tag, ".word"}, tx_data, mem[k]);
            step();
        end
        check({tag, ".emp1"}, transmit_empty, 1'b1);
        eop_done = 1'b1;
        #1;
        check({tag, ".done"}, data_done, 1'b1);
        step();
        eop_done = 1'b0;
        data_req = 1'b0;
        #1;
        check({tag, ".done0"}, data_done, 1'b0);
    endtask

    task automatic data_pkt(input string tag, input int len,
                            input logic [15:0] pid);
        clr_fifo();
        data_len   = LEN_W'(len);
        fifo_level = LEN_W'(len);
        data_req   = 1'b1;
        step();
        check({tag, ".pid"}, tx_data, pid);
        check({tag, ".st0"}, transmit_start, 1'b0);
        step();
        check({tag, ".st1"}, transmit_start, 1'b1);
        body(tag, len);
        wait_idle(tag);
    endtask

    task automatic hs_pkt(input string tag, input logic [1:0] code,
                          input logic [15:0] pid);
        hs_req  = 1'b1;
        hs_code = code;
        step();
        check({tag, ".pid"}, tx_data, pid);
        check({tag, ".rsp0"}, transmit_response, 1'b0);
        step();
        check({tag, ".rsp1"}, transmit_response, 1'b1);
        check({tag, ".gnt"}, hs_gnt, 1'b1);
        hs_req = 1'b0;
        step();
        check({tag, ".gnt0"}, hs_gnt, 1'b0);
        eop_done = 1'b1;
        #1;
        check({tag, ".nodone"}, data_done, 1'b0);
        step();
        eop_done = 1'b0;
        wait_idle(tag);
    endtask

    initial begin
        int n;
        logic bad;
        n_chk = 0;
        n_pass = 0;
        n_rst = 1'b0;
        usb_reset = 1'b0;
        hs_req = 1'b0;
        hs_code = 2'b00;
        data_req = 1'b0;
        data_len = '0;
        ack_rcvd = 1'b0;
        toggle_clr = 1'b0;
        fifo_level = '0;
        read_enable = 1'b0;
        eop_done = 1'b0;
        rp_clr = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        clr_fifo();
        step();
        check("rst.busy", busy, 1'b0);
        check("rst.emp", transmit_empty, 1'b1);
        check("rst.tx", tx_data, 16'h0000);
        check("rst.pulses", {hs_gnt, transmit_start, transmit_response,
                             fifo_rd, data_done}, 5'b0);
        n_rst = 1'b1;
        step();

        hs_pkt("ack", 2'b00, 16'h00D2);
        hs_pkt("rsvd", 2'b11, 16'h001E);

        mem[0] = 16'hA5A5;
        mem[1] = 16'h1234;
        data_pkt("d0", 2, 16'h00C3);

        ack_rcvd = 1'b1;
        step();
        ack_rcvd = 1'b0;
        data_pkt("d1", 2, 16'h004B);

        ack_rcvd = 1'b1;
        toggle_clr = 1'b1;
        step();
        ack_rcvd = 1'b0;
        toggle_clr = 1'b0;
        data_pkt("len0", 0, 16'h00C3);

        // Same-cycle requests: handshake first, data after the gap.
        clr_fifo();
        mem[0] = 16'hBEEF;
        hs_req = 1'b1;
        hs_code = 2'b01;
        data_req = 1'b1;
        data_len = 7'd1;
        fifo_level = 7'd1;
        step();
        check("arb.pid", tx_data, 16'h005A);
        step();
        check("arb.gnt", hs_gnt, 1'b1);
        check("arb.nost", transmit_start, 1'b0);
        hs_req = 1'b0;
        step();
        eop_done = 1'b1;
        step();
        eop_done = 1'b0;
        n = 0;
        while (!transmit_start && n < 60) begin
            step();
            n++;
        end
        // IPG gap cycles, one IDLE arbitration cycle, one DATA_START.
        check("arb.lat", n, IPG + 2);
        check("arb.dpid", tx_data, 16'h00C3);
        body("arb", 1);
        wait_idle("arb");

        // Underfilled FIFO holds the request.
        clr_fifo();
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        data_req = 1'b1;
        data_len = 7'd3;
        fifo_level = 7'd2;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            bad = bad | transmit_start | busy;
        end
        check("lvl.hold", bad, 1'b0);
        fifo_level = 7'd3;
        step();
        check("lvl.st0", transmit_start, 1'b0);
        check("lvl.pid", tx_data, 16'h00C3);
        step();
        check("lvl.st1", transmit_start, 1'b1);
        body("lvl", 3);
        wait_idle("lvl");

        // usb_reset mid DATA_BODY.
        ack_rcvd = 1'b1;
        step();
        ack_rcvd = 1'b0;
        clr_fifo();
        mem[0] = 16'hA5A5;
        mem[1] = 16'h1234;
        data_req = 1'b1;
        data_len = 7'd2;
        fifo_level = 7'd2;
        step();
        check("ur.pid", tx_data, 16'h004B);
        step();
        read_enable = 1'b1;
        step();
        read_enable = 1'b0;
        check("ur.word", tx_data, 16'hA5A5);
        usb_reset = 1'b1;
        step();
        usb_reset = 1'b0;
        data_req = 1'b0;
        check("ur.busy", busy, 1'b0);
        check("ur.emp", transmit_empty, 1'b1);
        eop_done = 1'b1;
        #1;
        check("ur.nodone", data_done, 1'b0);
        step();
        eop_done = 1'b0;
        data_pkt("ur.tgl", 0, 16'h00C3);

        // Async n_rst mid-packet.
        ack_rcvd = 1'b1;
        step();
        ack_rcvd = 1'b0;
        clr_fifo();
        data_req = 1'b1;
        data_len = 7'd2;
        fifo_level = 7'd2;
        step();
        step();
        read_enable = 1'b1;
        step();
        read_enable = 1'b0;
        n_rst = 1'b0;
        #1;
        check("por.busy", busy, 1'b0);
        check("por.tx", tx_data, 16'h0000);
        check("por.emp", transmit_empty, 1'b1);
        check("por.pulses", {hs_gnt, transmit_start, transmit_response,
                             fifo_rd, data_done}, 5'b0);
        data_req = 1'b0;
        step();
        n_rst = 1'b1;
        step();
        data_pkt("por.tgl", 0, 16'h00C3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
